// File: rtl/seg_pkg.sv
// seg_pkg: high-active glyph table, blank code and nibble decoder for the hex scanner
package seg_pkg;
   typedef logic [6:0] segT;
   localparam segT BLANK   = 7'h00;
   localparam segT GLYPH_0 = 7'h3F;
   localparam segT GLYPH_1 = 7'h06;
   localparam segT GLYPH_2 = 7'h5B;
   localparam segT GLYPH_3 = 7'h4F;
   localparam segT GLYPH_4 = 7'h66;
   localparam segT GLYPH_5 = 7'h6D;
   localparam segT GLYPH_6 = 7'h7D;
   localparam segT GLYPH_7 = 7'h27;
   localparam segT GLYPH_8 = 7'h7F;
   localparam segT GLYPH_9 = 7'h6F;
   localparam segT GLYPH_A = 7'h77;
   localparam segT GLYPH_B = 7'h7C;
   localparam segT GLYPH_C = 7'h39;
   localparam segT GLYPH_D = 7'h5E;
   localparam segT GLYPH_E = 7'h79;
   localparam segT GLYPH_F = 7'h71;
   function automatic segT hex_to_seg(input logic [3:0] nibble);
      case (nibble)
         4'h0: return GLYPH_0;
         4'h1: return GLYPH_1;
         4'h2: return GLYPH_2;
         4'h3: return GLYPH_3;
         4'h4: return GLYPH_4;
         4'h5: return GLYPH_5;
         4'h6: return GLYPH_6;
         4'h7: return GLYPH_7;
         4'h8: return GLYPH_8;
         4'h9: return GLYPH_9;
         4'hA: return GLYPH_A;
         4'hB: return GLYPH_B;
         4'hC: return GLYPH_C;
         4'hD: return GLYPH_D;
         4'hE: return GLYPH_E;
         default: return GLYPH_F;
      endcase
   endfunction
endpackage

// File: rtl/seg_glyph.sv
// seg_glyph: shared combinational nibble/blank to high-active 7-segment decoder
module seg_glyph import seg_pkg::*; (
   input  logic [3:0] nibble,
   input  logic       blank,
   output segT        seg
);
   assign seg = blank ? BLANK : hex_to_seg(nibble);
endmodule

// File: rtl/seg_hex_scan.sv
// seg_hex_scan: time-multiplexed hex display driver with tear-free frame-boundary loads
module seg_hex_scan import seg_pkg::*; #(
   parameter int DIGITS     = 4,
   parameter int CLK_DIV    = 50000,
   parameter int BLINK_DIV  = 64,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                iCLK,
   input  logic                iRST,
   input  logic                iEN,
   input  logic [4*DIGITS-1:0] iDATA,
   input  logic                iLOAD,
   input  logic [DIGITS-1:0]   iDP,
   input  logic [DIGITS-1:0]   iBLINK_MASK,
   input  logic                iBLANK_LZ,
   output logic [6:0]          oSEG,
   output logic                oDP,
   output logic [DIGITS-1:0]   oDIG_SEL,
   output logic                oFRAME
);
   localparam int CW = $clog2(CLK_DIV);
   localparam int IW = $clog2(DIGITS);
   localparam int FW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
   localparam logic POL = ACTIVE_LOW != 0;

   logic [CW-1:0]       preCnt;
   logic [IW-1:0]       digIdx;
   logic [FW-1:0]       frameCnt;
   logic                phase, pending, frameEndQ;
   logic [4*DIGITS-1:0] shadowData, dispData;
   logic [DIGITS-1:0]   shadowDp, shadowMask, dispDp, dispMask, lzMask, digOneHot;
   logic                tick, frameEnd, blinkWrap, blinkOff, lzOff, allZero;
   logic [3:0]          nibble;
   segT                 glyph;

   assign tick      = iEN && preCnt == CW'(CLK_DIV - 1);
   assign frameEnd  = tick && digIdx == IW'(DIGITS - 1);
   assign blinkWrap = frameCnt == FW'(BLINK_DIV - 1);
   assign nibble    = dispData[{digIdx, 2'b00} +: 4];
   assign blinkOff  = phase && dispMask[digIdx];
   assign lzOff     = iBLANK_LZ && lzMask[digIdx];
   assign digOneHot = DIGITS'(1) << digIdx;

   // Digit k is a leading zero when it and every more significant nibble are 0; digit 0 always shows
   always_comb begin
      lzMask  = '0;
      allZero = 1'b1;
      for (int k = DIGITS - 1; k > 0; k--) begin
         allZero   = allZero && dispData[4*k +: 4] == 4'd0;
         lzMask[k] = allZero;
      end
   end

   seg_glyph glyphDec (
      .nibble(nibble),
      .blank (blinkOff || lzOff),
      .seg   (glyph)
   );

   // Scan timing, blink phase, and shadow/display handoff at frame boundaries
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         preCnt     <= '0;
         digIdx     <= '0;
         frameCnt   <= '0;
         phase      <= 1'b0;
         pending    <= 1'b0;
         frameEndQ  <= 1'b0;
         oFRAME     <= 1'b0;
         shadowData <= '0;
         shadowDp   <= '0;
         shadowMask <= '0;
         dispData   <= '0;
         dispDp     <= '0;
         dispMask   <= '0;
      end else begin
         if (iEN) preCnt <= tick ? '0 : preCnt + CW'(1);
         if (tick) digIdx <= frameEnd ? '0 : digIdx + IW'(1);
         if (frameEnd) frameCnt <= blinkWrap ? '0 : frameCnt + FW'(1);
         if (frameEnd && blinkWrap) phase <= ~phase;
         if (iLOAD) begin
            shadowData <= iDATA;
            shadowDp   <= iDP;
            shadowMask <= iBLINK_MASK;
         end
         if (frameEnd && iLOAD) begin
            dispData <= iDATA;
            dispDp   <= iDP;
            dispMask <= iBLINK_MASK;
         end else if (frameEnd && pending) begin
            dispData <= shadowData;
            dispDp   <= shadowDp;
            dispMask <= shadowMask;
         end
         pending   <= frameEnd ? 1'b0 : (pending || iLOAD);
         frameEndQ <= frameEnd;
         oFRAME    <= frameEndQ;
      end
   end

   // Output pins: inactive in reset or while disabled, otherwise the selected digit
   always_ff @(posedge iCLK) begin
      if (iRST || !iEN) begin
         oSEG     <= {7{POL}};
         oDP      <= POL;
         oDIG_SEL <= {DIGITS{POL}};
      end else begin
         oSEG     <= glyph ^ {7{POL}};
         oDP      <= (dispDp[digIdx] && !blinkOff) ^ POL;
         oDIG_SEL <= digOneHot ^ {DIGITS{POL}};
      end
   end
endmodule

// File: tb/tb_seg_hex_scan.sv
// tb_seg_hex_scan: scoreboard bench for the 4-digit, CLK_DIV=4, BLINK_DIV=2, low-active configuration
module tb_seg_hex_scan;
   logic        clk = 1'b0;
   logic        iRST, iEN, iLOAD, iBLANK_LZ;
   logic [15:0] iDATA;
   logic [3:0]  iDP, iBLINK_MASK;
   logic [6:0]  oSEG;
   logic        oDP;
   logic [3:0]  oDIG_SEL;
   logic        oFRAME;
   int          checks = 0;
   int          errors = 0;
   logic [12:0] sb [$];
   logic [6:0]  glyphs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   localparam logic [12:0] OFF = {4'hF, 7'h7F, 1'b1, 1'b0};

   always #5 clk = ~clk;

   seg_hex_scan #(.DIGITS(4), .CLK_DIV(4), .BLINK_DIV(2), .ACTIVE_LOW(1)) dut (
      .iCLK(clk), .iRST(iRST), .iEN(iEN), .iDATA(iDATA), .iLOAD(iLOAD), .iDP(iDP),
      .iBLINK_MASK(iBLINK_MASK), .iBLANK_LZ(iBLANK_LZ), .oSEG(oSEG), .oDP(oDP),
      .oDIG_SEL(oDIG_SEL), .oFRAME(oFRAME)
   );

   // Expected {sel, seg, dp, frame} for digit d given display contents, low-active pins
   function automatic logic [12:0] exp_vec(int d, logic [15:0] data, logic [3:0] dp, logic [3:0] mask,
                                           logic ph, logic lz, logic fr);
      logic       blink;
      logic       blank;
      logic [3:0] nib;
      blink = ph && mask[d];
      nib   = data[4*d +: 4];
      blank = blink || (lz && d > 0 && (data >> (4*d)) == 16'd0);
      return {~(4'b0001 << d), blank ? 7'h7F : ~glyphs[nib], ~(dp[d] && !blink), fr};
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(logic lz);
      @(negedge clk);
      iRST = 1'b1; iEN = 1'b1; iLOAD = 1'b0; iDATA = '0; iDP = '0; iBLINK_MASK = '0; iBLANK_LZ = lz;
      step();
      iRST = 1'b0;
   endtask

   task automatic test_reset();
      logic [12:0] obs;
      @(negedge clk);
      iRST = 1'b1; iEN = 1'b1; iLOAD = 1'b1; iDATA = 16'hFFFF; iDP = 4'hF; iBLINK_MASK = '0; iBLANK_LZ = 1'b0;
      step();
      obs = {oDIG_SEL, oSEG, oDP, oFRAME};
      checks++;
      if (obs !== OFF) begin errors++; $display("FAIL reset_state got %h expected %h", obs, OFF); end
      iRST = 1'b0; iLOAD = 1'b0;
      obs = {oDIG_SEL, oSEG, oDP, oFRAME};
      checks++;
      if (obs !== OFF) begin errors++; $display("FAIL reset_release got %h expected %h", obs, OFF); end
      step();
      obs = {oDIG_SEL, oSEG, oDP, oFRAME};
      checks++;
      if (obs !== exp_vec(0, 16'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0)) begin
         errors++; $display("FAIL reset_first_digit got %h expected %h", obs, exp_vec(0, 16'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0));
      end
   endtask

   task automatic test_scan();
      logic [12:0] e, obs;
      do_reset(1'b0);
      for (int s = 0; s < 48; s++) sb.push_back(exp_vec((s/4)%4, 16'h0, 4'h0, 4'h0, 1'b0, 1'b0, s%16 == 0 && s > 0));
      for (int s = 0; s < 48; s++) begin
         step();
         e = sb.pop_front(); obs = {oDIG_SEL, oSEG, oDP, oFRAME};
         checks++;
         if (obs !== e) begin errors++; $display("FAIL scan s=%0d got %h expected %h", s, obs, e); end
      end
   endtask

   task automatic test_load_midframe();
      logic [12:0] e, obs;
      do_reset(1'b0);
      iDATA = 16'h1A3F;
      for (int s = 0; s < 32; s++) sb.push_back(exp_vec((s/4)%4, s < 16 ? 16'h0 : 16'h1A3F, 4'h0, 4'h0, 1'b0, 1'b0, s == 16));
      for (int s = 0; s < 32; s++) begin
         step();
         e = sb.pop_front(); obs = {oDIG_SEL, oSEG, oDP, oFRAME};
         checks++;
         if (obs !== e) begin errors++; $display("FAIL load_midframe s=%0d got %h expected %h", s, obs, e); end
         iLOAD = (s == 5);
      end
   endtask

   task automatic test_back_to_back();
      logic [12:0] e, obs;
      logic [15:0] d;
      do_reset(1'b0);
      for (int s = 0; s < 48; s++) begin
         d = s < 16 ? 16'h0 : (s < 32 ? 16'h0007 : 16'h00C0);
         sb.push_back(exp_vec((s/4)%4, d, 4'h0, 4'h0, 1'b0, 1'b0, s%16 == 0 && s > 0));
      end
      for (int s = 0; s < 48; s++) begin
         step();
         e = sb.pop_front(); obs = {oDIG_SEL, oSEG, oDP, oFRAME};
         checks++;
         if (obs !== e) begin errors++; $display("FAIL back_to_back s=%0d got %h expected %h", s, obs, e); end
         iLOAD = (s == 14 || s == 20);
         iDATA = s < 16 ? 16'h0007 : 16'h00C0;
      end
   endtask

   task automatic test_lz();
      logic [12:0] e, obs;
      do_reset(1'b1);
      iDATA = 16'h0050;
      for (int s = 0; s < 32; s++) sb.push_back(exp_vec((s/4)%4, s < 16 ? 16'h0 : 16'h0050, 4'h0, 4'h0, 1'b0, 1'b1, s == 16));
      for (int s = 0; s < 32; s++) begin
         step();
         e = sb.pop_front(); obs = {oDIG_SEL, oSEG, oDP, oFRAME};
         checks++;
         if (obs !== e) begin errors++; $display("FAIL leading_zero s=%0d got %h expected %h", s, obs, e); end
         iLOAD = (s == 2);
      end
      iBLANK_LZ = 1'b0;
   endtask

   task automatic test_blink();
      logic [12:0] e, obs;
      int f;
      do_reset(1'b0);
      iDATA = 16'h1238; iDP = 4'b0001; iBLINK_MASK = 4'b0001;
      for (int s = 0; s < 80; s++) begin
         f = s / 16;
         sb.push_back(f == 0 ? exp_vec((s/4)%4, 16'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0)
                             : exp_vec((s/4)%4, 16'h1238, 4'b0001, 4'b0001, ((f >> 1) & 1) == 1, 1'b0, s%16 == 0));
      end
      for (int s = 0; s < 80; s++) begin
         step();
         e = sb.pop_front(); obs = {oDIG_SEL, oSEG, oDP, oFRAME};
         checks++;
         if (obs !== e) begin errors++; $display("FAIL blink s=%0d got %h expected %h", s, obs, e); end
         iLOAD = (s == 2);
      end
   endtask

   task automatic test_enable_reset();
      logic [12:0] e, obs;
      int r;
      do_reset(1'b0);
      for (int s = 0; s < 50; s++) begin
         r = s - 16;
         if (s < 6) e = exp_vec((s/4)%4, 16'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
         else if (s < 11) e = OFF;
         else if (s < 13) e = exp_vec(1, 16'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
         else if (s < 15) e = exp_vec(2, 16'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
         else if (s == 15) e = OFF;
         else e = exp_vec((r/4)%4, 16'h0, 4'h0, 4'h0, 1'b0, 1'b0, r%16 == 0 && r > 0);
         sb.push_back(e);
      end
      for (int s = 0; s < 50; s++) begin
         step();
         e = sb.pop_front(); obs = {oDIG_SEL, oSEG, oDP, oFRAME};
         checks++;
         if (obs !== e) begin errors++; $display("FAIL enable_reset s=%0d got %h expected %h", s, obs, e); end
         iEN   = !(s >= 5 && s < 10);
         iLOAD = (s == 6 || s == 14);
         iDATA = s < 10 ? 16'h4444 : 16'h7777;
         iRST  = (s == 14);
      end
   endtask

   initial begin
      iRST = 1'b1; iEN = 1'b0; iLOAD = 1'b0; iDATA = '0; iDP = '0; iBLINK_MASK = '0; iBLANK_LZ = 1'b0;
      test_reset();
      test_scan();
      test_load_midframe();
      test_back_to_back();
      test_lz();
      test_blink();
      test_enable_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout after %0d checks", checks);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/seg_hex_scan.md
# seg_hex_scan

Time-multiplexed, parametrised hex display driver for common-segment multi-digit 7-segment modules. It replaces per-digit static decoders with one shared glyph decoder and a scan sequencer. Scan data loads tear-free at frame boundaries, with per-digit decimal point, per-digit blink and optional leading-zero blanking. It sits between register/counter logic and the board's segment and digit-select pins.

## Interface
Parameters:
- DIGITS, 4, number of digits scanned (2..8)
- CLK_DIV, 50000, clock cycles each digit is held (≥2)
- BLINK_DIV, 64, frames per blink half-period (≥1)
- ACTIVE_LOW, 1, 1 = segments, DP and digit selects are driven low-active; 0 = high-active

Ports:
- iCLK  in  1  clock; single clock domain
- iRST  in  1  synchronous, active-high reset
- iEN  in  1  scan enable; 0 freezes scan and forces outputs off
- iDATA  in  4*DIGITS  hex nibbles; nibble k drives digit k, digit 0 = least significant
- iLOAD  in  1  one-cycle strobe that captures iDATA, iDP and iBLINK_MASK
- iDP  in  DIGITS  decimal point per digit
- iBLINK_MASK  in  DIGITS  1 = digit blinks
- iBLANK_LZ  in  1  leading-zero blanking enable, sampled live
- oSEG  out  7  segments, bit0 = a … bit6 = g
- oDP  out  1  decimal point of the selected digit
- oDIG_SEL  out  DIGITS  one-hot digit select (one-cold when ACTIVE_LOW)
- oFRAME  out  1  one-cycle pulse when the last digit's slot ends

## Operation
- Prescaler counts 0..CLK_DIV-1. The terminal count is `tick`.
- Digit index advances on each tick: 0→1→…→DIGITS-1→0. `frame_end` = tick with index DIGITS-1.
- Shadow registers: iLOAD writes the shadow and sets `pending`. Multiple loads within one frame: last wins.
- On frame_end with `pending`, shadow copies to the display registers and `pending` clears.
- iLOAD in the same cycle as frame_end: iDATA/iDP/iBLINK_MASK write the display registers directly and `pending` clears.
- Blink: frame counter 0..BLINK_DIV-1 toggles `phase` at wrap. When `phase`=1, digits with their mask bit set show blank; their DP also blanks.
- Leading-zero blanking (iBLANK_LZ=1): digit k blanks if every display nibble from k up to DIGITS-1 is 0. Digit 0 never blanks, so value 0 shows "0". DP is not affected.
- Glyphs use the standard 0-F set: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=27 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71, in high-active hex. ACTIVE_LOW inverts all outputs.
- Blank = all segments inactive. The digit select still asserts, keeping the scan duty uniform.
- iEN=0: prescaler, index and frame counter hold; oSEG, oDP and oDIG_SEL are inactive. Loads are still accepted, and commit at the next frame_end after re-enable.

## Timing
- All outputs are registered and reflect state with one cycle of latency.
- Reset values (cycle after iRST high): oSEG, oDP and oDIG_SEL all inactive; oFRAME=0. Prescaler, index, frame counter, phase, pending, shadow and display registers all = 0.
- First cycle after reset release: outputs still inactive. The next cycle selects digit 0 showing "0".
- Each digit holds for exactly CLK_DIV cycles, so a frame = DIGITS*CLK_DIV cycles.
- oFRAME rises the cycle after frame_end. The newly committed data is visible from that same cycle, on digit 0.
- iRST mid-frame: all state returns to reset values on the next edge and overrides iLOAD. Any pending load is discarded.

## Structure
- Package seg_pkg holds the 16 glyph constants (high-active), function hex_to_seg(nibble), and the BLANK constant.
- Sub-module seg_glyph is the combinational nibble/blank → 7-bit segments decoder, instantiated once.
- Top level contains the prescaler, index counter, frame/blink counter, shadow/commit logic, LZ mask and output registers.

## Test plan
All tests use DIGITS=4, CLK_DIV=4, BLINK_DIV=2, ACTIVE_LOW=1.
- Reset then iEN=1: oDIG_SEL cycles 1110→1101→1011→0111, each held 4 cycles. oSEG=40 ("0") on every digit. oFRAME pulses every 16 cycles.
- Load iDATA=16'h1A3F mid-frame:
  - old values until oFRAME.
  - Then the digits show 0E ("F") on digit 0, 30 ("3") on digit 1, 08 ("A") on digit 2, 79 ("1") on digit 3.
- iLOAD coinciding with frame_end: the new value appears on digit 0 the next cycle. A second load later in the same frame is deferred to the following frame.
- iBLANK_LZ=1, data 16'h0050: digits 3 and 2 show 7F, digit 1 shows 12 ("5"), digit 0 shows 40. With data 16'h0000, only digit 0 shows 40.
- iBLINK_MASK=4'b0001 with iDP=4'b0001: digit 0 segments and oDP alternate visible/blank every 2 frames. Other digits remain steady.
- iEN=0 mid-frame, then iRST during the scan: outputs go inactive and the index freezes. Reset returns all outputs inactive and restarts the scan at digit 0 showing "0".
